fetch_inst_buf: RTL and testbench

Instruction buffer between the fetch stage and `decode_top`. Fetched instruction/PC pairs are written into a small in-order FIFO. The buffer then drives the decoder-side fetch/decode signals: `inst_e_`, `inst_pc` and `inst`, and it honours `dec_stall`. This decouples instruction-cache return timing from decoder back-pressure, and a redirect flush discards all buffered instructions.

---
 rtl/fetch_inst_buf.sv | 94 +++++++++
 tb/tb_fetch_inst_buf.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_inst_buf.sv
// fetch_inst_buf: in-order instruction/PC FIFO between fetch and decode.
// Decouples icache return timing from decoder back-pressure.
module fetch_inst_buf #(
    parameter int ADDR  = 32,
    parameter int INST  = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset_,
    input  logic                       flush,
    input  logic                       ic_e_,
    input  logic [ADDR-1:0]            ic_pc,
    input  logic [INST-1:0]            ic_inst,
    output logic                       buf_full,
    output logic [$clog2(DEPTH):0]     buf_cnt,
    input  logic                       dec_stall,
    output logic                       inst_e_,
    output logic [ADDR-1:0]            inst_pc,
    output logic [INST-1:0]            inst
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR-1:0] pc_mem   [DEPTH];
    logic [INST-1:0] inst_mem [DEPTH];

    logic [PW-1:0] rp;
    logic [PW-1:0] wp;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          empty;
    logic          push;
    logic          pop;

    assign empty    = (cnt == '0);
    assign buf_full = (cnt == CW'(DEPTH));
    assign buf_cnt  = cnt;

    // A full buffer rejects pushes even when a pop frees a slot this cycle.
    assign push = !ic_e_ && !buf_full && !flush;
    assign pop  = !empty && !dec_stall && !flush;

    // Occupancy bookkeeping; push and pop together cancel out.
    always_comb begin
        cnt_nxt = cnt;
        unique case ({push, pop})
            2'b10:   cnt_nxt = cnt + CW'(1);
            2'b01:   cnt_nxt = cnt - CW'(1);
            default: cnt_nxt = cnt;
        endcase
    end

    // Pointer and counter state; flush wins over any handshake.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            rp  <= '0;
            wp  <= '0;
            cnt <= '0;
        end else if (flush) begin
            rp  <= '0;
            wp  <= '0;
            cnt <= '0;
        end else begin
            if (push) begin
                wp <= wp + PW'(1);
            end
            if (pop) begin
                rp <= rp + PW'(1);
            end
            cnt <= cnt_nxt;
        end
    end

    // Entry storage; contents are don't-care after reset or flush.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wp]   <= ic_pc;
            inst_mem[wp] <= ic_inst;
        end
    end

    // Head presentation; zeroed while the buffer is empty.
    always_comb begin
        inst_e_ = empty;
        inst_pc = '0;
        inst    = '0;
        if (!empty) begin
            inst_pc = pc_mem[rp];
            inst    = inst_mem[rp];
        end
    end

endmodule

// File: tb/tb_fetch_inst_buf.sv
// tb_fetch_inst_buf: directed bench with a queue-based reference model.
// Every negedge compares the DUT against the model; directed literals pin it.
module tb_fetch_inst_buf;

    logic        clk;
    logic        reset_;
    logic        flush;
    logic        ic_e_;
    logic [31:0] ic_pc;
    logic [31:0] ic_inst;
    logic        buf_full;
    logic [2:0]  buf_cnt;
    logic        dec_stall;
    logic        inst_e_;
    logic [31:0] inst_pc;
    logic [31:0] inst;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] in;
    } ent_t;

    ent_t q[$];

    fetch_inst_buf #(.ADDR(32), .INST(32), .DEPTH(4)) dut (
        .clk      (clk),
        .reset_   (reset_),
        .flush    (flush),
        .ic_e_    (ic_e_),
        .ic_pc    (ic_pc),
        .ic_inst  (ic_inst),
        .buf_full (buf_full),
        .buf_cnt  (buf_cnt),
        .dec_stall(dec_stall),
        .inst_e_  (inst_e_),
        .inst_pc  (inst_pc),
        .inst     (inst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input logic [31:0] pc);
        return {16'hC0DE, pc[15:0]};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: FIFO of accepted pairs, cleared by reset or flush.
    always @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            q.delete();
        end else begin
            bit full;
            bit do_push;
            bit do_pop;
            full    = (q.size() == 4);
            do_push = !ic_e_ && !full && !flush;
            do_pop  = (q.size() > 0) && !dec_stall && !flush;
            if (flush) begin
                q.delete();
            end else begin
                if (do_pop) void'(q.pop_front());
                if (do_push) q.push_back('{pc: ic_pc, in: ic_inst});
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        chk("m_inst_e", 64'(inst_e_), 64'(q.size() == 0));
        chk("m_pc", 64'(inst_pc), 64'(q.size() > 0 ? q[0].pc : 32'h0));
        chk("m_inst", 64'(inst), 64'(q.size() > 0 ? q[0].in : 32'h0));
        chk("m_cnt", 64'(buf_cnt), 64'(q.size()));
        chk("m_full", 64'(buf_full), 64'(q.size() == 4));
    end

    task automatic drv(input logic ie, input logic [31:0] pc,
                       input logic st, input logic fl);
        ic_e_     = ie;
        ic_pc     = pc;
        ic_inst   = mk(pc);
        dec_stall = st;
        flush     = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_ = 1'b0;
        drv(1'b1, 32'h0, 1'b0, 1'b0);
        tick();
        tick();
        reset_ = 1'b1;
        chk("rst_inst_e", 64'(inst_e_), 64'd1);
        chk("rst_cnt", 64'(buf_cnt), 64'd0);

        // reset mid-cycle with 3 entries buffered
        for (int i = 0; i < 3; i++) begin
            drv(1'b0, 32'h80 + 32'(i * 4), 1'b1, 1'b0);
            tick();
        end
        drv(1'b1, 32'h0, 1'b1, 1'b0);
        chk("pre_rst_cnt", 64'(buf_cnt), 64'd3);
        #3;
        reset_ = 1'b0;
        #1;
        chk("arst_inst_e", 64'(inst_e_), 64'd1);
        chk("arst_pc", 64'(inst_pc), 64'd0);
        chk("arst_inst", 64'(inst), 64'd0);
        chk("arst_cnt", 64'(buf_cnt), 64'd0);
        chk("arst_full", 64'(buf_full), 64'd0);
        tick();
        reset_ = 1'b1;
        tick();

        // streaming 8 entries, no stall
        for (int i = 0; i < 8; i++) begin
            drv(1'b0, 32'h100 + 32'(i * 4), 1'b0, 1'b0);
            tick();
            if (i == 0) begin
                chk("str_first_pc", 64'(inst_pc), 64'h100);
                chk("str_first_inst", 64'(inst), 64'hC0DE0100);
            end
            chk("str_cnt", 64'(buf_cnt), 64'd1);
        end
        drv(1'b1, 32'h0, 1'b0, 1'b0);
        chk("str_last_pc", 64'(inst_pc), 64'h11C);
        tick();
        chk("str_empty", 64'(inst_e_), 64'd1);

        // full / back-pressure
        for (int i = 0; i < 4; i++) begin
            drv(1'b0, 32'h100 + 32'(i * 4), 1'b1, 1'b0);
            tick();
        end
        chk("bp_full", 64'(buf_full), 64'd1);
        chk("bp_cnt4", 64'(buf_cnt), 64'd4);
        chk("bp_head", 64'(inst_pc), 64'h100);
        drv(1'b0, 32'h110, 1'b1, 1'b0);
        tick();
        chk("bp_rej_cnt", 64'(buf_cnt), 64'd4);
        chk("bp_rej_head", 64'(inst_pc), 64'h100);

        // full plus simultaneous pop: pop only
        drv(1'b0, 32'h110, 1'b0, 1'b0);
        tick();
        chk("fp_cnt3", 64'(buf_cnt), 64'd3);
        chk("fp_head", 64'(inst_pc), 64'h104);
        tick();
        chk("fp_acc_cnt", 64'(buf_cnt), 64'd3);
        chk("fp_acc_head", 64'(inst_pc), 64'h108);
        drv(1'b1, 32'h0, 1'b0, 1'b0);
        tick();
        chk("dr_10c", 64'(inst_pc), 64'h10C);
        tick();
        chk("dr_110", 64'(inst_pc), 64'h110);
        chk("dr_110_inst", 64'(inst), 64'hC0DE0110);
        tick();
        chk("dr_empty", 64'(inst_e_), 64'd1);

        // flush with push and pop requested
        for (int i = 0; i < 3; i++) begin
            drv(1'b0, 32'h300 + 32'(i * 4), 1'b1, 1'b0);
            tick();
        end
        drv(1'b0, 32'h30C, 1'b0, 1'b1);
        tick();
        chk("fl_cnt", 64'(buf_cnt), 64'd0);
        chk("fl_inst_e", 64'(inst_e_), 64'd1);
        chk("fl_pc", 64'(inst_pc), 64'd0);
        drv(1'b0, 32'h200, 1'b1, 1'b0);
        tick();
        chk("fl_new_pc", 64'(inst_pc), 64'h200);
        chk("fl_new_cnt", 64'(buf_cnt), 64'd1);
        drv(1'b1, 32'h0, 1'b0, 1'b0);
        tick();
        chk("fl_drained", 64'(inst_e_), 64'd1);

        // push and pop together at cnt==1
        drv(1'b0, 32'h400, 1'b0, 1'b0);
        tick();
        chk("c1_head0", 64'(inst_pc), 64'h400);
        drv(1'b0, 32'h404, 1'b0, 1'b0);
        tick();
        chk("c1_cnt", 64'(buf_cnt), 64'd1);
        chk("c1_inst_e", 64'(inst_e_), 64'd0);
        chk("c1_head1", 64'(inst_pc), 64'h404);
        chk("c1_inst1", 64'(inst), 64'hC0DE0404);
        drv(1'b1, 32'h0, 1'b0, 1'b0);
        tick();
        chk("c1_empty", 64'(inst_e_), 64'd1);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
